// File: rtl/dds_freq_meter.sv
// Frequency meter for an offset-binary sine stream: hysteretic rising-crossing
// detector, 2^AVG_LOG2-period averaging, and a restoring divide into an fword estimate.
module dds_freq_meter #(
    parameter int unsigned AVG_LOG2    = 4,
    parameter int unsigned MID         = 128,
    parameter int unsigned HYST        = 16,
    parameter int unsigned TIMEOUT_CYC = 32'd1 << 24,
    parameter int unsigned CNT_W       = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        din_valid,
    input  logic [7:0]  din,
    output logic [31:0] fword_est,
    output logic        est_valid,
    output logic        busy,
    output logic        timeout
);

    localparam int unsigned QW     = 33 + AVG_LOG2;
    localparam int unsigned STEP_W = $clog2(QW);
    localparam int unsigned NC_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYC + 1);

    localparam logic [7:0]        HI        = 8'(MID + HYST);
    localparam logic [7:0]        LO        = 8'(MID - HYST);
    localparam logic [NC_W-1:0]   NC_LAST   = NC_W'((1 << AVG_LOG2) - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(QW - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_MEASURE,
        S_DIVIDE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               armed_q, armed_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NC_W-1:0]    ncross_q, ncross_d;
    logic [TO_W-1:0]    tcnt_q, tcnt_d;
    logic [CNT_W-1:0]   div_q, div_d;
    logic [CNT_W:0]     rem_q, rem_d;
    logic [QW-1:0]      quo_q, quo_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [31:0]        fword_q, fword_d;
    logic               est_q, est_d;
    logic               tout_q, tout_d;

    logic               xing;
    logic               to_hit;
    logic [CNT_W:0]     rem_sh;
    logic               rem_ge;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ncross_d = ncross_q;
        div_d    = div_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        step_d   = step_q;
        fword_d  = fword_q;
        est_d    = 1'b0;
        tout_d   = 1'b0;
        tcnt_d   = '0;

        xing   = din_valid && armed_q && (din >= HI);
        to_hit = (tcnt_q == TO_LAST);

        if (state_q == S_IDLE)
            armed_d = 1'b0;
        else if (din_valid && (din < LO))
            armed_d = 1'b1;
        else if (xing)
            armed_d = 1'b0;
        else
            armed_d = armed_q;

        // Dividend is a single 1 followed by zeros, so only step 0 shifts in a 1.
        rem_sh = {rem_q[CNT_W-1:0], (step_q == '0)};
        rem_ge = (rem_sh >= {1'b0, div_q});

        if (state_q == S_SYNC || state_q == S_MEASURE)
            tcnt_d = tcnt_q + TO_W'(1);

        case (state_q)
            S_IDLE: begin
                if (en)
                    state_d = S_SYNC;
            end
            S_SYNC: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else if (xing) begin
                    cnt_d    = '0;
                    ncross_d = '0;
                    tcnt_d   = '0;
                    state_d  = S_MEASURE;
                end else if (to_hit) begin
                    tout_d  = 1'b1;
                    fword_d = '0;
                    tcnt_d  = '0;
                end
            end
            S_MEASURE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!en) begin
                    state_d = S_IDLE;
                end else if (xing) begin
                    tcnt_d = '0;
                    if (ncross_q == NC_LAST) begin
                        div_d   = cnt_q + CNT_W'(1);
                        rem_d   = '0;
                        quo_d   = '0;
                        step_d  = '0;
                        state_d = S_DIVIDE;
                    end else begin
                        ncross_d = ncross_q + NC_W'(1);
                    end
                end else if (to_hit) begin
                    tout_d  = 1'b1;
                    fword_d = '0;
                    tcnt_d  = '0;
                    state_d = S_SYNC;
                end
            end
            S_DIVIDE: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d  = rem_ge ? (rem_sh - {1'b0, div_q}) : rem_sh;
                    quo_d  = {quo_q[QW-2:0], rem_ge};
                    step_d = step_q + STEP_W'(1);
                    if (step_q == STEP_LAST)
                        state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else begin
                    est_d   = 1'b1;
                    fword_d = (|quo_q[QW-1:32]) ? '1 : quo_q[31:0];
                    state_d = S_SYNC;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            armed_q  <= 1'b0;
            cnt_q    <= '0;
            ncross_q <= '0;
            tcnt_q   <= '0;
            div_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            step_q   <= '0;
            fword_q  <= '0;
            est_q    <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            armed_q  <= armed_d;
            cnt_q    <= cnt_d;
            ncross_q <= ncross_d;
            tcnt_q   <= tcnt_d;
            div_q    <= div_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            step_q   <= step_d;
            fword_q  <= fword_d;
            est_q    <= est_d;
            tout_q   <= tout_d;
        end
    end

    assign fword_est = fword_q;
    assign est_valid = est_q;
    assign timeout   = tout_q;
    assign busy      = (state_q != S_IDLE);

endmodule
